// File: rtl/control_multiciclo_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit:
// opcodes, ALUOp encodings, state encoding and the control bundle.
package mips_ctrl_defs;

    localparam int ST_BITS = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_WB_R   = 4'd3;
    localparam logic [3:0] ST_ADDR   = 4'd4;
    localparam logic [3:0] ST_MEM_RD = 4'd5;
    localparam logic [3:0] ST_MEM_WR = 4'd6;
    localparam logic [3:0] ST_WB_MEM = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_EXEC_I = 4'd9;
    localparam logic [3:0] ST_WB_I   = 4'd10;
    localparam logic [3:0] ST_TRAP   = 4'd15;

    typedef enum logic [ST_BITS-1:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC_R = ST_EXEC_R,
        S_WB_R   = ST_WB_R,
        S_ADDR   = ST_ADDR,
        S_MEM_RD = ST_MEM_RD,
        S_MEM_WR = ST_MEM_WR,
        S_WB_MEM = ST_WB_MEM,
        S_BRANCH = ST_BRANCH,
        S_EXEC_I = ST_EXEC_I,
        S_WB_I   = ST_WB_I,
        S_TRAP   = ST_TRAP
    } state_t;

    typedef struct packed {
        logic       MemToReg;
        logic       MemRead;
        logic       RegWrite;
        logic       MemToWrite;
        logic       RegDst;
        logic       branch;
        logic       ALUSrc;
        logic [2:0] ALUOp;
        logic       pc_write;
        logic       ir_write;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control bundle decoder.
// Ports: state_i (current state), mem_ready_i (gates FETCH strobes), ctrl_o.
module ctrl_out_decode
    import mips_ctrl_defs::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.MemRead  = 1'b1;
                ctrl_o.ir_write = mem_ready_i;
                ctrl_o.pc_write = mem_ready_i;
            end
            S_EXEC_R: ctrl_o.ALUOp = ALU_RTYPE;
            S_ADDR: begin
                ctrl_o.ALUSrc = 1'b1;
                ctrl_o.ALUOp  = ALU_ADD;
            end
            S_MEM_RD: ctrl_o.MemRead    = 1'b1;
            S_MEM_WR: ctrl_o.MemToWrite = 1'b1;
            S_WB_R: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.RegDst   = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.MemToReg = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.ALUOp  = ALU_SUB;
            end
`ifdef CTRL_ADDI_EN
            S_EXEC_I: begin
                ctrl_o.ALUSrc = 1'b1;
                ctrl_o.ALUOp  = ALU_ADD;
            end
            S_WB_I: ctrl_o.RegWrite = 1'b1;
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS control FSM; drives datapath control bundle, pc/ir strobes,
// sticky illegal flag and debug state. Optional ADDI support: CTRL_ADDI_EN.
module control_multiciclo
    import mips_ctrl_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opc,
    input  logic               mem_ready,
    output logic               MemToReg,
    output logic               MemRead,
    output logic               RegWrite,
    output logic               MemToWrite,
    output logic               RegDst,
    output logic               branch,
    output logic               ALUSrc,
    output logic [2:0]         ALUOp,
    output logic               pc_write,
    output logic               ir_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t     state_q, state_d;
    logic [5:0] opc_q, opc_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opc_d = Opc;
                unique case (Opc)
                    OP_R:    state_d = S_EXEC_R;
                    OP_LW:   state_d = S_ADDR;
                    OP_SW:   state_d = S_ADDR;
                    OP_BEQ:  state_d = S_BRANCH;
`ifdef CTRL_ADDI_EN
                    OP_ADDI: state_d = S_EXEC_I;
`endif
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            // Only LW/SW reach ADDR, so anything but LW is a store.
            S_ADDR:   state_d = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_WB_R:   state_d = S_FETCH;
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
`ifdef CTRL_ADDI_EN
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   state_d = S_FETCH;
`endif
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        // Set alongside TRAP entry so the flag is visible in TRAP's first cycle.
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    ctrl_out_decode u_dec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign MemToReg   = ctrl.MemToReg;
    assign MemRead    = ctrl.MemRead;
    assign RegWrite   = ctrl.RegWrite;
    assign MemToWrite = ctrl.MemToWrite;
    assign RegDst     = ctrl.RegDst;
    assign branch     = ctrl.branch;
    assign ALUSrc     = ctrl.ALUSrc;
    assign ALUOp      = ctrl.ALUOp;
    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign illegal    = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multi-cycle MIPS control FSM that sequences the shared datapath (single ALU, unified instruction/data memory, register file) across fetch, decode, execute, memory and write-back steps. It takes the IR opcode and a memory ready handshake. Each cycle it drives the same control bundle the single-cycle decoder produces (MemToReg, MemRead, RegWrite, MemToWrite, RegDst, branch, ALUSrc, ALUOp), plus pc_write and ir_write. It sits between the instruction register and the datapath muxes in the multi-cycle core.

## Interface
- STATE_W, 4, width of state register and debug state output
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Opc  input  6  opcode from the instruction register; sampled only in DECODE
- mem_ready  input  1  memory completes the current access this cycle
- MemToReg  output  1  write-back source: 1 = memory data register, 0 = ALUOut
- MemRead  output  1  memory read request (instruction or data)
- RegWrite  output  1  register file write enable
- MemToWrite  output  1  memory write request
- RegDst  output  1  destination select: 1 = rd, 0 = rt
- branch  output  1  branch enable; the datapath ANDs it with ALU zero to load the PC
- ALUSrc  output  1  ALU B operand: 1 = sign-extended immediate, 0 = register B
- ALUOp  output  3  000 add, 010 subtract, 001 R-type (funct decoded downstream)
- pc_write  output  1  PC <= PC+4
- ir_write  output  1  IR load enable
- illegal  output  1  sticky; set on an unsupported opcode
- state  output  STATE_W  current state, for debug

## Operation
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000 (macro-gated).
- States and transitions:
  - FETCH: if mem_ready then DECODE, else hold.
  - DECODE goes to one of:
    - EXEC_R for R.
    - ADDR for LW/SW.
    - BRANCH for BEQ.
    - EXEC_I for ADDI.
    - TRAP for anything else.
  - EXEC_R: go to WB_R.
  - EXEC_I: go to WB_I.
  - ADDR: go to MEM_RD for LW, MEM_WR for SW. Uses the opcode latched in DECODE.
  - MEM_RD: if mem_ready then WB_MEM, else hold.
  - MEM_WR: if mem_ready then FETCH, else hold.
  - WB_R, WB_I, WB_MEM, BRANCH: go to FETCH.
  - TRAP: absorbing until rst.
- Outputs per state; any output not listed is 0:
  - FETCH: MemRead=1. ir_write=mem_ready. pc_write=mem_ready.
  - DECODE: none.
  - EXEC_R: ALUOp=001.
  - EXEC_I: ALUSrc=1, ALUOp=000.
  - ADDR: ALUSrc=1, ALUOp=000.
  - MEM_RD: MemRead=1.
  - MEM_WR: MemToWrite=1.
  - WB_R: RegWrite=1, RegDst=1.
  - WB_I: RegWrite=1, RegDst=0, MemToReg=0.
  - WB_MEM: RegWrite=1, RegDst=0, MemToReg=1.
  - BRANCH: branch=1, ALUOp=010.
  - TRAP: none.
- Opcode latch: Opc is captured into an internal register on leaving DECODE. Later states never look at live Opc.
- MemRead and MemToWrite are never high in the same cycle. RegWrite is high only in a WB_* state.

## Timing
- Outputs are decoded from the state register. The only exceptions are ir_write and pc_write in FETCH, which are gated combinationally by mem_ready.
- Latency from FETCH entry to the next FETCH, with mem_ready always 1:
  - R: 4 cycles.
  - ADDI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs stay constant during the wait.
- Reset: on a clk edge with rst=1, the next state is FETCH and illegal clears to 0.
- Outputs in the cycle after reset:
  - MemRead=1.
  - ir_write and pc_write follow mem_ready.
  - All other outputs are 0.
  - state is the FETCH encoding (0).
- rst has priority over every transition, including mid-wait in MEM_RD or MEM_WR. An aborted store does not re-issue.
- illegal goes high on the first cycle in TRAP and stays high until reset.

## Configuration
- CTRL_ADDI_EN defined: opcode 001000 decodes to EXEC_I → WB_I.
- CTRL_ADDI_EN undefined: the EXEC_I and WB_I states are not built, and 001000 goes to TRAP.

## Structure
- Shared package/header `mips_ctrl_defs` holds:
  - the opcode constants;
  - the ALUOp encodings (000, 001, 010);
  - the state encoding localparams.
- Sub-module `ctrl_out_decode`: a purely combinational state → control-bundle decoder, instantiated once.

## Test plan
- Reset, then R-type (Opc=000000), mem_ready=1:
  - states FETCH, DECODE, EXEC_R, WB_R, FETCH;
  - ALUOp=001 in EXEC_R;
  - RegWrite=1 and RegDst=1 in WB_R only.
- LW (100011) with mem_ready held low 2 cycles in MEM_RD:
  - 7 cycles FETCH→FETCH;
  - MemRead stable 3 cycles;
  - WB_MEM shows MemToReg=1, RegWrite=1.
- SW (101011):
  - MemToWrite=1 exactly 1 cycle;
  - RegWrite never 1;
  - back to FETCH after 4 cycles.
- BEQ (000100):
  - branch=1 and ALUOp=010 in the 3rd cycle;
  - pc_write=1 only in FETCH.
- Opc=111111 → TRAP:
  - illegal=1 and stays sticky for 10 cycles;
  - rst pulse → FETCH, illegal=0.
- rst asserted during MEM_WR wait → FETCH next cycle, MemToWrite=0.
- With CTRL_ADDI_EN undefined, 001000 → illegal=1.
